// File: rtl/vid_mem_resp.sv
// Burst memory target: accepts read/write bursts, bids for the bus to return read data or a write response.
// Optional VID_MEM_RESP_RANGE_ERR_EN: out-of-range requests return cmdout=111 instead of aliasing.
module vid_mem_resp #(
  parameter int         DEPTH  = 256,
  parameter logic [3:0] TGT_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic [2:0]  cmdout,
  output logic [3:0]  reqtar
);
  localparam int AW = $clog2(DEPTH);

`ifdef VID_MEM_RESP_RANGE_ERR_EN
  localparam bit RANGE_ERR_EN = 1'b1;
`else
  localparam bit RANGE_ERR_EN = 1'b0;
`endif

  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] CMD_BEAT = 3'b011;
  localparam logic [2:0] CMD_WR   = 3'b100;
  localparam logic [2:0] CMD_WRSP = 3'b101;
  localparam logic [2:0] CMD_ERR  = 3'b111;

  typedef enum logic [2:0] {IDLE, RD_BID, RD_DATA, WR_DATA, WR_BID} state_t;

  state_t         state;
  logic [AW-1:0]  idx;
  logic [3:0]     cnt;
  logic [1:0]     len_q;
  logic           err_q;
  logic [31:0]    mem [DEPTH];

  logic req_rd, req_wr, beat, hi_nz, wr_en;
  assign req_rd = selin && (cmdin == CMD_RD);
  assign req_wr = selin && (cmdin == CMD_WR);
  assign beat   = selin && (cmdin == CMD_BEAT);
  assign hi_nz  = |addrdatain[31:AW+2];
  // Erroneous write bursts still walk idx/cnt so every beat is consumed.
  assign wr_en  = (state == WR_DATA) && beat && !err_q;

  // Memory has no reset: contents survive reset and aborted bursts.
  always_ff @(posedge clk)
    if (wr_en) mem[idx] <= addrdatain;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      reqout      <= 2'b00;
      lenout      <= 2'b00;
      addrdataout <= '0;
      cmdout      <= 3'b000;
      reqtar      <= 4'd0;
      idx         <= '0;
      cnt         <= 4'd0;
      len_q       <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          reqout      <= 2'b00;
          lenout      <= 2'b00;
          addrdataout <= '0;
          cmdout      <= 3'b000;
          reqtar      <= 4'd0;
          if (req_rd || req_wr) begin
            idx   <= addrdatain[AW+1:2];
            len_q <= lenin;
            cnt   <= 4'd1 << lenin;
            err_q <= RANGE_ERR_EN & hi_nz;
          end
          if (req_rd) begin
            state  <= RD_BID;
            reqout <= 2'b11;
            reqtar <= TGT_ID;
            lenout <= lenin;
          end else if (req_wr) begin
            state <= WR_DATA;
          end
        end
        RD_BID: if (ackin) begin
          reqout <= 2'b00;
          reqtar <= 4'd0;
          if (err_q) begin
            cmdout      <= CMD_ERR;
            addrdataout <= '0;
            state       <= IDLE;
          end else begin
            cmdout      <= CMD_BEAT;
            addrdataout <= mem[idx];
            idx         <= idx + AW'(1);
            cnt         <= cnt - 4'd1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (cnt != 4'd0) begin
            addrdataout <= mem[idx];
            idx         <= idx + AW'(1);
            cnt         <= cnt - 4'd1;
          end else begin
            cmdout      <= 3'b000;
            addrdataout <= '0;
            lenout      <= 2'b00;
            state       <= IDLE;
          end
        end
        WR_DATA: if (beat) begin
          idx <= idx + AW'(1);
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= WR_BID;
            reqout <= 2'b11;
            reqtar <= TGT_ID;
            lenout <= len_q;
          end
        end
        WR_BID: if (ackin) begin
          reqout <= 2'b00;
          reqtar <= 4'd0;
          cmdout <= err_q ? CMD_ERR : CMD_WRSP;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/vid_mem_resp.md
VID_MEM_RESP -- requirements
Module: vid_mem_resp

Interface
REQ-001: Parameter DEPTH, default 256, memory size in 32-bit words, power of two, 4..4096.
REQ-002: Parameter TGT_ID, default 4'd1, value driven on reqtar while bidding.
REQ-003: Port clk  input  1  single clock; all logic on rising edge.
REQ-004: Port reset  input  1  synchronous, active-high reset.
REQ-005: Port selin  input  1  block selected for the current bus cycle.
REQ-006: Port cmdin  input  3  command: 010 read req, 011 data beat, 100 write req; others ignored.
REQ-007: Port lenin  input  2  burst length code; beats = 1<<lenin (1,2,4,8).
REQ-008: Port addrdatain  input  32  byte address on request cycles, write data on beats.
REQ-009: Port ackin  input  1  arbiter grant for this block's bid.
REQ-010: Port reqout  output  2  bus bid; 11 = bidding, 00 = none.
REQ-011: Port lenout  output  2  length code of the burst being returned.
REQ-012: Port addrdataout  output  32  read data during read beats, else 0.
REQ-013: Port cmdout  output  3  011 read data, 101 write response, 111 error (macro only), 000 idle.
REQ-014: Port reqtar  output  4  TGT_ID while reqout=11, else 0.

Function
REQ-015: FSM states IDLE, RD_BID, RD_DATA, WR_DATA, WR_BID; all outputs registered.
REQ-016: IDLE: selin=1 and cmdin=010 latches word index addrdatain[log2(DEPTH)+1:2], lenin, beat count; next RD_BID.
REQ-017: IDLE: selin=1 and cmdin=100 latches index and lenin; next WR_DATA.
REQ-018: IDLE with any other cmdin, or selin=0, holds IDLE and drives idle outputs.
REQ-019: RD_BID: reqout=11, reqtar=TGT_ID, lenout=latched len; holds until ackin=1, then RD_DATA next cycle.
REQ-020: RD_DATA: one beat per cycle, cmdout=011, addrdataout=mem[index], index+1 per beat.
REQ-021: Read data appears on the cycle after ackin is sampled high; beats are back-to-back, no stalls.
REQ-022: After the last beat, next cycle returns to IDLE with reqout=00, cmdout=000, addrdataout=0.
REQ-023: WR_DATA: each cycle with selin=1 and cmdin=011 writes addrdatain to mem[index], index+1; other cycles wait.
REQ-024: After the last write beat, WR_BID: reqout=11 until ackin=1; next cycle cmdout=101 for exactly one cycle, then IDLE.
REQ-025: Index increments modulo DEPTH (wrap from DEPTH-1 to 0) within a burst.
REQ-026: Requests arriving while not IDLE are ignored; no queueing.
REQ-027: ackin while not bidding is ignored.
REQ-028: Burst of 1 (lenin=00) produces exactly one read beat or accepts exactly one write beat.

Reset
REQ-029: reset=1 at clock edge forces IDLE and reqout=0, lenout=0, addrdataout=0, cmdout=0, reqtar=0.
REQ-030: Reset mid-burst aborts with no further beats or response; writes already completed remain.
REQ-031: Memory contents are not cleared by reset.

Configuration
REQ-032: Macro VID_MEM_RESP_RANGE_ERR_EN defined: request address at or above DEPTH*4 is not serviced; after bid/ack one cycle cmdout=111, addrdataout=0, then IDLE; write beats of that burst are consumed but discarded.
REQ-033: Macro undefined: upper address bits ignored; index aliases modulo DEPTH; cmdout never 111.

Verification
REQ-034: Write 4 beats (100, addr 0x10, lenin=10, data 1..4), ack after 2 cycles -> cmdout=101 for 1 cycle; read back 0x10 len 4 -> beats 1,2,3,4 with cmdout=011.
REQ-035: Read addr (DEPTH-2)*4 lenin=10 after seeding -> beats mem[254],mem[255],mem[0],mem[1].
REQ-036: Read request, ackin held low 5 cycles -> reqout=11, reqtar=1, no data until cycle after ack.
REQ-037: Reset asserted on 2nd of 8 read beats -> next cycle all outputs 0, IDLE, no further beats.
REQ-038: Second read request during RD_DATA -> ignored; exactly original beat count returned.
REQ-039: With VID_MEM_RESP_RANGE_ERR_EN, read addr 0x400 -> one cycle cmdout=111 after ack; without it, returns mem[0].
